// File: rtl/isp_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isp_stream_pkg
//  Description : Shared types and defaults for the raw Bayer stream source.
//                Holds the transmitter state enum, the Bayer colour enum, the
//                CFA colour lookup and the default framing constants.
//  Revision    : 1.0  initial release
// ============================================================================
package isp_stream_pkg;

    localparam int DEFAULT_START_GAP = 32;
    localparam int DEFAULT_HBLANK    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_FBLANK = 3'd5,
        ST_DONE   = 3'd6
    } tx_state_t;

    typedef enum logic [1:0] {
        BAYER_R = 2'd0,
        BAYER_G = 2'd1,
        BAYER_B = 2'd2
    } bayer_color_t;

    // CFA layout: even rows are G B G B ..., odd rows are R G R G ...
    function automatic bayer_color_t bayer_color(input logic row_odd, input logic col_odd);
        if (row_odd) begin
            return col_odd ? BAYER_G : BAYER_R;
        end
        return col_odd ? BAYER_B : BAYER_G;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_mosaic_sel.sv
`default_nettype none
// ============================================================================
//  Module      : bayer_mosaic_sel
//  Description : Combinational Bayer mosaic. Picks the one colour channel of
//                a full RGB pixel that the CFA keeps at this row/column parity.
//  Ports       : row_odd  in   1   row parity (1 = odd row)
//                col_odd  in   1   column parity (1 = odd column)
//                rgb      in  24   {R[23:16], G[15:8], B[7:0]}
//                sample   out  8   selected raw sample
//  Revision    : 1.0  initial release
// ============================================================================
module bayer_mosaic_sel
    import isp_stream_pkg::*;
(
    input  logic        row_odd,
    input  logic        col_odd,
    input  logic [23:0] rgb,
    output logic [7:0]  sample
);

    always_comb begin
        sample = rgb[15:8];
        case (bayer_color(row_odd, col_odd))
            BAYER_R: sample = rgb[23:16];
            BAYER_B: sample = rgb[7:0];
            default: sample = rgb[15:8];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bayer_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bayer_stream_tx
//  Description : Raw Bayer stream source for the ISP. Accepts RGB pixels over
//                ready/valid, mosaics them to one 8-bit sample per pixel and
//                frames them with a start gap, per-row blanking and a flush
//                phase that runs until the downstream pipe reports done.
//  Ports       : clk        in   1   system clock
//                reset      in   1   synchronous active-high reset
//                iStart     in   1   begin one frame (sampled in IDLE)
//                iRGB       in  24   source pixel {R,G,B}
//                iRGBValid  in   1   source pixel valid
//                oRGBReady  out  1   source pixel accepted this cycle
//                oNewFrame  out  1   frame-start pulse
//                oValid     out  1   raw sample valid
//                oData      out  8   raw Bayer sample
//                iPipeDone  in   1   downstream done (level or pulse)
//                oBusy      out  1   block not idle
//                oFrameDone out  1   frame-complete pulse
//                oTimeout   out  1   flush limit hit (FLUSH_TIMEOUT_EN only)
//  Options     : `define FLUSH_TIMEOUT_EN to bound the number of flush rows
//                by MAX_FLUSH_ROWS and add the oTimeout output.
//  Revision    : 1.0  initial release
// ============================================================================
module bayer_stream_tx
    import isp_stream_pkg::*;
#(
    parameter int width          = 320,
    parameter int height         = 240,
    parameter int START_GAP      = DEFAULT_START_GAP,
    parameter int HBLANK         = DEFAULT_HBLANK,
    parameter int MAX_FLUSH_ROWS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic [23:0] iRGB,
    input  logic        iRGBValid,
    output logic        oRGBReady,
    output logic        oNewFrame,
    output logic        oValid,
    output logic [7:0]  oData,
    input  logic        iPipeDone,
    output logic        oBusy,
`ifdef FLUSH_TIMEOUT_EN
    output logic        oTimeout,
`endif
    output logic        oFrameDone
);

    localparam int GAP_MAX = (START_GAP > HBLANK) ? START_GAP : HBLANK;
    localparam int COL_W   = (width   > 1) ? $clog2(width)   : 1;
    localparam int ROW_W   = (height  > 1) ? $clog2(height)  : 1;
    localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

    if (width < 1 || height < 1 || START_GAP < 1 || HBLANK < 1 || MAX_FLUSH_ROWS < 1) begin : g_bad_params
        $error("bayer_stream_tx: size parameters must all be at least 1");
    end

    tx_state_t          state;
    tx_state_t          state_next;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [GAP_W-1:0]   gap_cnt;
    logic               done_sticky;
    logic               flush_limit;
    logic               xfer;
    logic               last_col;
    logic               last_row;
    logic               gap_end;
    logic               blank_end;
    logic               done_now;
    logic [7:0]         mosaic_sample;

    logic               valid_d;
    logic [7:0]         data_d;
    logic               new_frame_d;
    logic               frame_done_d;
    logic               busy_d;

    assign oRGBReady = (state == ST_ACTIVE);
    assign xfer      = iRGBValid & oRGBReady;
    assign last_col  = (col == COL_W'(width - 1));
    assign last_row  = (row == ROW_W'(height - 1));
    assign gap_end   = (gap_cnt == GAP_W'(START_GAP - 1));
    assign blank_end = (gap_cnt == GAP_W'(HBLANK - 1));
    // A done arriving on the very cycle of the last flush pixel still counts.
    assign done_now  = done_sticky | iPipeDone;

    bayer_mosaic_sel u_mosaic (
        .row_odd (row[0]),
        .col_odd (col[0]),
        .rgb     (iRGB),
        .sample  (mosaic_sample)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (iStart)           state_next = ST_GAP;
            ST_GAP:    if (gap_end)          state_next = ST_ACTIVE;
            ST_ACTIVE: if (xfer && last_col) state_next = ST_HBLANK;
            ST_HBLANK: if (blank_end)        state_next = last_row ? ST_FLUSH : ST_ACTIVE;
            ST_FLUSH:  if (last_col)         state_next = (done_now || flush_limit) ? ST_DONE : ST_FBLANK;
            ST_FBLANK: if (blank_end)        state_next = ST_FLUSH;
            ST_DONE:                         state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic (next values of output registers) -------
    always_comb begin
        valid_d      = 1'b0;
        data_d       = 8'h00;
        new_frame_d  = (state == ST_IDLE) && iStart;
        frame_done_d = (state == ST_DONE);
        busy_d       = (state != ST_IDLE);
        if (state == ST_ACTIVE && xfer) begin
            valid_d = 1'b1;
            data_d  = mosaic_sample;
        end else if (state == ST_FLUSH) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oValid     <= 1'b0;
            oData      <= 8'h00;
            oNewFrame  <= 1'b0;
            oFrameDone <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            oValid     <= valid_d;
            oData      <= data_d;
            oNewFrame  <= new_frame_d;
            oFrameDone <= frame_done_d;
            oBusy      <= busy_d;
        end
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            gap_cnt     <= '0;
            done_sticky <= 1'b0;
        end else begin
            // One shared down-time counter: restarts on every state change.
            if (state_next != state) begin
                gap_cnt <= '0;
            end else if (state == ST_GAP || state == ST_HBLANK || state == ST_FBLANK) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            // Column advances on accepted pixels and on every flush cycle.
            if ((state == ST_ACTIVE && xfer) || state == ST_FLUSH) begin
                col <= last_col ? '0 : col + COL_W'(1);
            end

            if (state == ST_HBLANK && blank_end) begin
                row <= last_row ? '0 : row + ROW_W'(1);
            end

            // Done is only tracked once flushing starts; earlier pulses drop.
            done_sticky <= (state == ST_FLUSH || state == ST_FBLANK)
                           && (state_next != ST_DONE) && done_now;
        end
    end

`ifdef FLUSH_TIMEOUT_EN
    localparam int FR_W = (MAX_FLUSH_ROWS > 1) ? $clog2(MAX_FLUSH_ROWS) : 1;

    logic [FR_W-1:0] flush_rows;
    logic            timeout_hit;

    assign flush_limit = (flush_rows == FR_W'(MAX_FLUSH_ROWS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_rows  <= '0;
            timeout_hit <= 1'b0;
            oTimeout    <= 1'b0;
        end else begin
            if (state == ST_IDLE || state == ST_DONE) begin
                flush_rows <= '0;
            end else if (state == ST_FLUSH && last_col) begin
                flush_rows <= flush_rows + FR_W'(1);
            end

            if (state == ST_IDLE) begin
                timeout_hit <= 1'b0;
            end else if (state == ST_FLUSH && last_col && !done_now && flush_limit) begin
                timeout_hit <= 1'b1;
            end

            // Raised together with oFrameDone, held until the next frame starts.
            if (state == ST_DONE && timeout_hit) begin
                oTimeout <= 1'b1;
            end else if (state == ST_IDLE && iStart) begin
                oTimeout <= 1'b0;
            end
        end
    end
`else
    assign flush_limit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bayer_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bayer_stream_tx
//  Description : Self-checking bench for bayer_stream_tx with a 4x2 frame,
//                START_GAP=4, HBLANK=2, MAX_FLUSH_ROWS=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bayer_stream_tx;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int SG  = 4;
    localparam int HB  = 2;
    localparam int MFR = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        iStart;
    logic [23:0] iRGB;
    logic        iRGBValid;
    logic        iPipeDone;
    logic        oRGBReady;
    logic        oNewFrame;
    logic        oValid;
    logic [7:0]  oData;
    logic        oBusy;
    logic        oFrameDone;
`ifdef FLUSH_TIMEOUT_EN
    logic        oTimeout;
`endif

    int tests  = 0;
    int failed = 0;
    int idx    = 0;

    typedef struct packed {
        logic       st;
        logic       v;
        logic       pd;
        logic       ev;
        logic [7:0] ed;
        logic       enf;
        logic       efd;
        logic       ebusy;
        logic       erdy;
    } vec_t;

    vec_t frame_tbl[$];
    vec_t stall_tbl[$];

    always #5 clk = ~clk;

    bayer_stream_tx #(
        .width          (W),
        .height         (H),
        .START_GAP      (SG),
        .HBLANK         (HB),
        .MAX_FLUSH_ROWS (MFR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iStart     (iStart),
        .iRGB       (iRGB),
        .iRGBValid  (iRGBValid),
        .oRGBReady  (oRGBReady),
        .oNewFrame  (oNewFrame),
        .oValid     (oValid),
        .oData      (oData),
        .iPipeDone  (iPipeDone),
        .oBusy      (oBusy),
`ifdef FLUSH_TIMEOUT_EN
        .oTimeout   (oTimeout),
`endif
        .oFrameDone (oFrameDone)
    );

    function automatic logic [23:0] pix(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'h10 + b, 8'h20 + b, 8'h30 + b};
    endfunction

    function automatic vec_t mk(input logic st, v, pd, ev, input logic [7:0] ed,
                                input logic enf, efd, ebusy, erdy);
        vec_t e;
        e = '{st: st, v: v, pd: pd, ev: ev, ed: ed, enf: enf, efd: efd, ebusy: ebusy, erdy: erdy};
        return e;
    endfunction

    // Inputs are driven on the falling edge; outputs are sampled on the next
    // falling edge, i.e. half a cycle after the rising edge that produced them.
    task automatic step(input logic r, st, v, pd);
        logic xfer;
        reset     = r;
        iStart    = st;
        iRGBValid = v;
        iPipeDone = pd;
        iRGB      = pix(idx);
        xfer      = v & oRGBReady & ~r;
        @(posedge clk);
        if (xfer === 1'b1) idx++;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic check_vec(input string nm, input int k, input vec_t e);
        logic ok;
        tests++;
        ok = (oValid === e.ev) && (oNewFrame === e.enf) && (oFrameDone === e.efd)
             && (oBusy === e.ebusy) && (oRGBReady === e.erdy)
             && (!e.ev || oData === e.ed);
        if (!ok) begin
            failed++;
            $display("FAIL %s step %0d: got v=%b d=%h nf=%b fd=%b busy=%b rdy=%b, want v=%b d=%h nf=%b fd=%b busy=%b rdy=%b",
                     nm, k, oValid, oData, oNewFrame, oFrameDone, oBusy, oRGBReady,
                     e.ev, e.ed, e.enf, e.efd, e.ebusy, e.erdy);
        end
    endtask

    task automatic run_tbl(input string nm, input vec_t t[$]);
        for (int k = 0; k < t.size(); k++) begin
            step(1'b0, t[k].st, t[k].v, t[k].pd);
            check_vec(nm, k, t[k]);
        end
    endtask

    initial begin
        int  nfc;
        int  vc;
        bit  seen;

        // ---- frame + flush-with-done trace: st v pd | ev ed nf fd busy rdy
        frame_tbl.push_back(mk(1, 1, 0, 0, 8'h00, 1, 0, 0, 0)); // start
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0)); // gap
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 1)); // now ACTIVE
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h20, 0, 0, 1, 1)); // row 0
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h31, 0, 0, 1, 1));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h22, 0, 0, 1, 1));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h33, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0)); // hblank
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 1));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h14, 0, 0, 1, 1)); // row 1
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h25, 0, 0, 1, 1));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h16, 0, 0, 1, 1));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h27, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0)); // hblank
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++)                              // flush row 1
            frame_tbl.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0)); // fblank
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0)); // flush row 2
        frame_tbl.push_back(mk(0, 1, 1, 1, 8'h00, 0, 0, 1, 0)); // done pulse
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0));
        frame_tbl.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0)); // last flush px
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 1, 0)); // frame done
        frame_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 0)); // idle

        // ---- source stall after pixel 1
        stall_tbl.push_back(mk(1, 1, 0, 0, 8'h00, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            stall_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0));
        stall_tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 1));
        stall_tbl.push_back(mk(0, 1, 0, 1, 8'h20, 0, 0, 1, 1));
        stall_tbl.push_back(mk(0, 1, 0, 1, 8'h31, 0, 0, 1, 1));
        for (int k = 0; k < 3; k++)
            stall_tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 1));
        stall_tbl.push_back(mk(0, 1, 0, 1, 8'h22, 0, 0, 1, 1)); // pixel 2 = G

        // ---- reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_outputs", {oValid, oData, oNewFrame, oFrameDone, oBusy, oRGBReady}, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // ---- frame pattern and flush with done
        idx = 0;
        run_tbl("frame", frame_tbl);

        // ---- stall, then reset mid-ACTIVE
        idx = 0;
        run_tbl("stall", stall_tbl);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("midframe_reset_outputs", {oValid, oData, oNewFrame, oFrameDone, oBusy, oRGBReady}, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("after_reset_idle", {oValid, oNewFrame, oFrameDone, oBusy, oRGBReady}, '0);
        idx = 0;
        run_tbl("replay", frame_tbl);

        // ---- iStart and iPipeDone held high for a whole frame
        nfc  = 0;
        vc   = 0;
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (oNewFrame) nfc++;
            if (oValid) vc++;
            if (oFrameDone) seen = 1;
        end
        chk("held_start_frame_done_seen", 32'(seen), 32'd1);
        chk("held_start_newframe_count", nfc, 32'd1);
        chk("held_start_valid_count", vc, 32'(W * H + W));
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("held_start_second_newframe", 32'(oNewFrame), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FLUSH_TIMEOUT_EN
        // ---- flush limit without any done
        nfc  = 0;
        vc   = 0;
        seen = 0;
        chk("timeout_idle_low", 32'(oTimeout), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 300 && !seen; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (oValid) vc++;
            if (oFrameDone) seen = 1;
        end
        chk("timeout_frame_done_seen", 32'(seen), 32'd1);
        chk("timeout_valid_count", vc, 32'(W * H + MFR * W));
        chk("timeout_with_frame_done", 32'(oTimeout), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("timeout_held", 32'(oTimeout), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_cleared_by_start", 32'(oTimeout), 32'd0);
        chk("timeout_restart_newframe", 32'(oNewFrame), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bayer_stream_tx.md
Name: bayer_stream_tx

Overview:
- Hardware source for the raw Bayer input stream of `processing`; drives its `newFrame`/`iValid`/`iData` inputs.
- Accepts full RGB pixels from an upstream ready/valid source and mosaics them to one 8-bit sample per pixel (GBGB on even rows, RGRG on odd rows).
- Frames the output with a start gap, per-row horizontal blanking and a trailing flush phase that keeps the pipeline moving until it reports done.

Parameters:
- width, 320, pixels per row
- height, 240, rows per frame
- START_GAP, 32, cycles from the `oNewFrame` pulse (inclusive) to the first pixel opportunity
- HBLANK, 16, `oValid`-low cycles after every row, active and flush rows alike
- MAX_FLUSH_ROWS, 8, flush-row limit; used only with FLUSH_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iStart  in  1  begin one frame; sampled in IDLE only
- iRGB  in  24  source pixel {R[23:16], G[15:8], B[7:0]}
- iRGBValid  in  1  source pixel valid
- oRGBReady  out  1  block accepts a source pixel this cycle
- oNewFrame  out  1  one-cycle frame-start pulse to the ISP
- oValid  out  1  pixel valid to the ISP
- oData  out  8  raw Bayer sample to the ISP
- iPipeDone  in  1  downstream demosaic done (level or pulse)
- oBusy  out  1  high in every state except IDLE
- oFrameDone  out  1  one-cycle pulse when the frame completes
- oTimeout  out  1  flush limit hit; exists only with FLUSH_TIMEOUT_EN

Behaviour:
- Reset: every output is 0 at the edge after `reset`. State goes to IDLE and all counters clear. Reset mid-frame aborts the frame with no `oFrameDone`.
- States: IDLE, GAP, ACTIVE, HBLANK, FLUSH, FBLANK, DONE.
- IDLE:
  - `iStart` moves to GAP and registers `oNewFrame=1` for exactly one cycle.
  - `iStart` in any other state is ignored.
- GAP:
  - The gap counter runs START_GAP-1 further cycles, then the state moves to ACTIVE.
  - `oValid=0` throughout.
- ACTIVE:
  - `oRGBReady=1`, derived from state only.
  - A transfer is `iRGBValid & oRGBReady`.
  - The cycle after a transfer, `oValid=1` and `oData` holds the mosaic sample (latency 1).
  - A cycle with no transfer gives `oValid=0`. Mid-row stalls are legal, and the column does not advance on them.
- Mosaic select, row r and column c:
  - r even: c even → G, c odd → B
  - r odd: c even → R, c odd → G
- Counters:
  - The column counter runs 0..width-1 and wraps to 0 on the transfer at width-1.
  - That same transfer moves the state to HBLANK; `oRGBReady` drops the next cycle.
  - The row counter increments when HBLANK exits.
- HBLANK:
  - Lasts HBLANK cycles with `oValid=0`.
  - Then goes to ACTIVE, or to FLUSH if the row just completed was row height-1.
- FLUSH:
  - Emits width cycles of `oValid=1`, `oData=0`, independent of the source. `oRGBReady=0`.
  - `iPipeDone` is latched sticky from FLUSH entry, so a single-cycle pulse is never lost.
  - On the last flush pixel: sticky done set → DONE; otherwise → FBLANK.
- FBLANK: HBLANK cycles with `oValid=0`, then FLUSH again.
- DONE: `oFrameDone=1` for one cycle, then IDLE. The sticky done flag clears.
- Simultaneous events:
  - `iPipeDone` arriving on the last flush pixel counts.
  - `iPipeDone` during ACTIVE or HBLANK is ignored and not latched.
  - A frame with height=1 still goes through HBLANK before FLUSH.
- Counter widths: `$clog2(width)`, `$clog2(height)`, `$clog2(max(START_GAP,HBLANK))`.

Optional Feature:
- Macro: FLUSH_TIMEOUT_EN.
- Defined:
  - A flush-row counter increments at the end of each flush row.
  - If MAX_FLUSH_ROWS rows complete without done, the block goes to DONE and asserts `oTimeout=1` with `oFrameDone`.
  - `oTimeout` holds until the next `iStart` or `reset`.
- Not defined:
  - FLUSH repeats indefinitely.
  - There is no `oTimeout` port and no flush-row counter.

Decomposition:
- Package `isp_stream_pkg`:
  - state enum `tx_state_t`
  - Bayer colour enum {BAYER_R, BAYER_G, BAYER_B}
  - default START_GAP and HBLANK constants, shared with the testbench
- Sub-module `bayer_mosaic_sel`: combinational; (row parity, column parity, 24-bit RGB) → 8-bit sample.
- FSM, counters and output registers stay in `bayer_stream_tx`.

Test Plan:
1. Frame pattern with width=4, height=2, START_GAP=4, HBLANK=2, source always valid, `iRGB` = {8'h10+i, 8'h20+i, 8'h30+i}. Required:
   - `oNewFrame` pulses once, and the first `oValid` comes 5 cycles after `iStart` is sampled.
   - `oData` = 20,31,22,33 for row 0 and 14,25,16,27 for row 1, each row followed by 2 low cycles.
2. Flush with done: hold `iPipeDone` low until the 2nd flush row, then pulse it for 1 cycle mid-row. Required:
   - Two 4-cycle runs of `oValid=1`, `oData=0`, separated by a 2-cycle gap.
   - `oFrameDone` the cycle after the final flush pixel.
   - `oBusy` low one cycle later.
3. Source stall: drop `iRGBValid` for 3 cycles after pixel 1. Required:
   - `oValid` low for exactly those 3 cycles.
   - Mosaic phase preserved: pixel 2 is still G.
4. Reset mid-ACTIVE at pixel 2. Required:
   - All outputs 0 at the next edge and the state is IDLE.
   - A new `iStart` replays the frame from row 0, column 0.
5. `iStart` held high throughout. Required: exactly one `oNewFrame` per frame, and a second frame starts only after `oFrameDone`.
6. With FLUSH_TIMEOUT_EN, MAX_FLUSH_ROWS=3, `iPipeDone` never asserted. Required:
   - 3 flush rows, then `oFrameDone=1` with `oTimeout=1`.
   - `oTimeout` clears on the next `iStart`.
